// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch/decode boundary queue.
// Optional statistics counters are enabled with IF_ID_QUEUE_STATS_EN.
package if_id_pkg;

   localparam int          XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

   // One buffered fetch result at the default datapath width
   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] instr;
      logic [XLEN_DEFAULT-1:0] pc_plus;
   } if_id_entry_t;

   // Occupancy counter must represent 0..depth inclusive
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/if_id_queue_ptr_ctrl.sv
// Read/write pointer and occupancy bookkeeping for if_id_queue.
// push/pop are re-qualified against full/empty so the count cannot wrap.
module ifq_ptr_ctrl
   import if_id_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   output logic [$clog2(DEPTH)-1:0]      rd_ptr,
   output logic [$clog2(DEPTH)-1:0]      wr_ptr,
   output logic [cnt_width(DEPTH)-1:0]   count,
   output logic                          full,
   output logic                          empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Next pointers/count; flush wins over any push/pop in the same cycle
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so natural overflow gives modulo wrap
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push_ok && !pop_ok) count_d = count_q + 1'b1;
         if (pop_ok && !push_ok) count_d = count_q - 1'b1;
      end
   end

   // Bookkeeping registers, reset wins over flush
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_ptr = rd_ptr_q;
   assign wr_ptr = wr_ptr_q;
   assign count  = count_q;

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry in-order IF/ID buffer of {instr, pc+step} with valid/ready
// on both sides and a synchronous flush. No same-cycle fall-through.
// Define IF_ID_QUEUE_STATS_EN to add full-stall and flush counters.
module if_id_queue
   import if_id_pkg::*;
#(
   parameter int XLEN    = XLEN_DEFAULT,
   parameter int DEPTH   = 2,
   parameter int PC_STEP = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [XLEN-1:0]               in_instr,
   input  logic [XLEN-1:0]               in_pc,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [XLEN-1:0]               out_instr,
   output logic [XLEN-1:0]               out_pc_plus,
   output logic [cnt_width(DEPTH)-1:0]   count
`ifdef IF_ID_QUEUE_STATS_EN
   ,
   output logic [31:0]                   full_stall_cnt,
   output logic [15:0]                   flush_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);

   // Local entry type so the storage follows XLEN
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_plus;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   entry_t        head;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic          full, empty, push, pop;

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   ifq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .pop    (pop),
      .flush  (flush),
      .rd_ptr (rd_ptr),
      .wr_ptr (wr_ptr),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   // Write the new entry at wr_ptr; a push in a flush cycle is dropped
   always_comb begin
      mem_d = mem_q;
      if (push && !flush) begin
         mem_d[wr_ptr].instr   = in_instr;
         mem_d[wr_ptr].pc_plus = in_pc + XLEN'(PC_STEP);
      end
   end

   // Storage carries data only; validity lives in the pointer block
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head        = mem_q[rd_ptr];
   assign out_instr   = out_valid ? head.instr   : XLEN'(NOP_INSTR);
   assign out_pc_plus = out_valid ? head.pc_plus : '0;

`ifdef IF_ID_QUEUE_STATS_EN
   logic [31:0] full_stall_cnt_q, full_stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters; flush does not clear them
   always_comb begin
      full_stall_cnt_d = full_stall_cnt_q;
      flush_cnt_d      = flush_cnt_q;
      if (in_valid && !in_ready && full_stall_cnt_q != 32'hFFFF_FFFF)
         full_stall_cnt_d = full_stall_cnt_q + 32'd1;
      if (flush && flush_cnt_q != 16'hFFFF)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   // Counter registers, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         full_stall_cnt_q <= '0;
         flush_cnt_q      <= '0;
      end else begin
         full_stall_cnt_q <= full_stall_cnt_d;
         flush_cnt_q      <= flush_cnt_d;
      end
   end

   assign full_stall_cnt = full_stall_cnt_q;
   assign flush_cnt      = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised fetch/decode boundary buffer. It replaces the single-entry IF/ID register with a DEPTH-entry in-order queue of {instruction, PC+step} pairs.
- Producer side is fetch; consumer side is decode. Both use a valid/ready handshake.
- A synchronous flush discards all entries on branch/jump redirect.
- Entries buffered while decode stalls (e.g. load-use hazard) are held, not lost.

Parameters:
XLEN, 32, width of instruction and PC fields
DEPTH, 2, number of queue entries; power of two, >= 2
PC_STEP, 4, constant added to in_pc on push

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  fetch presents an entry
in_ready  out  1  queue can accept an entry this cycle
in_instr  in  XLEN  fetched instruction word
in_pc  in  XLEN  PC of the fetched instruction
flush  in  1  discard all entries (synchronous)
out_valid  out  1  head entry available to decode
out_ready  in  1  decode consumes the head this cycle
out_instr  out  XLEN  head instruction; NOP_INSTR when empty
out_pc_plus  out  XLEN  head PC+PC_STEP; 0 when empty
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clocking and reset:
  - Reset is synchronous and active-high, on clk.
  - Reset effect: count=0, read/write pointers=0, out_valid=0, out_instr=NOP_INSTR, out_pc_plus=0, in_ready=1 in the first cycle after reset.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It is combinational from registered state only, with no path from out_ready.
  - out_valid = (count != 0).
  - out_instr and out_pc_plus are read from storage at rd_ptr, gated to NOP_INSTR/0 when empty.
- Latency:
  - A pushed entry appears on out_* in the cycle after the push edge; there is no same-cycle fall-through.
  - Throughput is one entry per cycle in each direction.
- Arithmetic:
  - On push, the stored pc_plus = in_pc + PC_STEP, truncated to XLEN (wraps modulo 2^XLEN).
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop (not full, not empty): both happen; count is unchanged, both pointers advance.
- Full: in_ready=0, so in_valid is ignored. A pop in that cycle frees a slot, but in_ready stays 0 for that cycle.
- Empty: out_ready is ignored and count never underflows.
- flush:
  - Next cycle: count=0 and pointers=0.
  - A push or pop in the flush cycle is discarded.
  - flush has priority over push/pop; rst has priority over flush.
- Entry data is held unchanged while not popped (decode stall). Storage contents are not cleared by rst/flush; only validity is.
- Reset asserted mid-stream has the same outcome as flush, plus reset of the optional counters.

Optional Feature:
IF_ID_QUEUE_STATS_EN
- Defined: adds two output ports, cleared only by rst and not by flush.
  - full_stall_cnt [31:0] increments each cycle with in_valid & !in_ready, saturating at 32'hFFFFFFFF.
  - flush_cnt [15:0] increments each cycle flush=1, saturating at 16'hFFFF.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package if_id_pkg:
  - XLEN_DEFAULT
  - NOP_INSTR (32'h00000000)
  - typedef if_id_entry_t {instr, pc_plus}
  - function clog2-based count width
- Sub-module ifq_ptr_ctrl owns rd_ptr, wr_ptr and count, with push/pop/flush inputs and full/empty outputs. Storage array and output gating stay in if_id_queue.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0, out_instr=0, count=0 for 3 cycles.
- Push in_instr=0x8C220004, in_pc=0x00000010 with out_ready=0:
  - Next cycle out_valid=1, out_pc_plus=0x00000014, count=1.
  - Held unchanged for 5 stall cycles.
- DEPTH=2, push 3 back-to-back with out_ready=0:
  - count=2, in_ready=0 after the 2nd.
  - The 3rd entry is not accepted.
  - Popping then yields entries 1 and 2 in order.
- Continuous push/pop stream of 8 entries: one output per cycle, count steady at 1, order preserved, pointers wrap.
- Full queue, then flush=1 together with in_valid=1 and out_ready=1:
  - Next cycle count=0, out_valid=0, out_instr=0.
  - No entry from the flush cycle survives.
- in_pc=0xFFFFFFFC pushed -> out_pc_plus=0x00000000.
- With IF_ID_QUEUE_STATS_EN: 4 full-stall cycles plus 1 flush -> full_stall_cnt=4, flush_cnt=1; flush leaves both unchanged.
